stream_downsizer: RTL and testbench



---
 rtl/stream_pkg.sv | 28 ++
 rtl/stream_downsizer.sv | 131 +++++++++++++
 tb/tb_stream_downsizer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
// Shared definitions for the streaming width-conversion blocks.
//   ratio()     : number of narrow beats carried by one wide word
//   cnt_width() : width of a beat counter able to index 0..ratio-1 (min 1 bit)
//   ctrl_state_e: two-state control encoding; ST_SEND means a word is held
// -----------------------------------------------------------------------------
package stream_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } ctrl_state_e;

    function automatic int ratio(input int in_bits, input int out_bits);
        return in_bits / out_bits;
    endfunction

    // A one-bit counter is still needed when only two beats exist
    function automatic int cnt_width(input int r);
        if (r <= 2) begin
            return 1;
        end else begin
            return $clog2(r);
        end
    endfunction

endpackage

// File: rtl/stream_downsizer.sv
// -----------------------------------------------------------------------------
// stream_downsizer
// Splits each IN_BITS upstream word into RATIO = IN_BITS/OUT_BITS beats of
// OUT_BITS, least-significant slice first. A continuous stream is carried at
// one beat per cycle with no bubble between consecutive words.
//
// Ports
//   clk              : clock, all state updates on the rising edge
//   rst              : synchronous active-high reset (wins over handshakes)
//   upstream_data    : wide word, sampled only when a word is accepted
//   upstream_valid   : upstream word valid
//   upstream_ready   : stage accepts a word this cycle
//   downstream_data  : current narrow beat
//   downstream_valid : beat valid
//   downstream_ready : consumer accepts the beat
//   downstream_last  : final beat of a word (only with STREAM_DOWNSIZER_LAST_EN)
//
// Configuration macro: STREAM_DOWNSIZER_LAST_EN adds the downstream_last port.
// -----------------------------------------------------------------------------
module stream_downsizer
    import stream_pkg::*;
#(
    parameter int IN_BITS  = 32,
    parameter int OUT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_BITS-1:0]  upstream_data,
    input  logic                upstream_valid,
    output logic                upstream_ready,
    output logic [OUT_BITS-1:0] downstream_data,
    output logic                downstream_valid,
    input  logic                downstream_ready
`ifdef STREAM_DOWNSIZER_LAST_EN
    ,
    output logic                downstream_last
`endif
);

    localparam int RATIO = ratio(IN_BITS, OUT_BITS);
    localparam int CW    = cnt_width(RATIO);
    localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if ((IN_BITS % OUT_BITS) != 0 || IN_BITS < 2 * OUT_BITS) begin : g_bad_params
        $error("stream_downsizer: IN_BITS must be a multiple of OUT_BITS and at least twice as wide");
    end

    ctrl_state_e         state_r;
    ctrl_state_e         state_nxt_s;
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       cnt_nxt_s;
    logic [IN_BITS-1:0]  sreg_r;
    logic [IN_BITS-1:0]  sreg_nxt_s;

    logic                full_s;
    logic                is_last_s;
    logic                beat_fire_s;
    logic                word_fire_s;

    assign full_s      = (state_r == ST_SEND);
    assign is_last_s   = (cnt_r == LAST_CNT);
    assign beat_fire_s = full_s & downstream_ready;
    // Combinational path from downstream_ready lets a new word load in the
    // same cycle the last beat leaves, keeping the stream bubble-free.
    assign upstream_ready = ~full_s | (downstream_ready & is_last_s);
    assign word_fire_s    = upstream_valid & upstream_ready;

    assign downstream_valid = full_s;
    assign downstream_data  = sreg_r[OUT_BITS-1:0];

`ifdef STREAM_DOWNSIZER_LAST_EN
    assign downstream_last = full_s & is_last_s;
`endif

    // Next-state logic for control state, beat counter and shift register
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        sreg_nxt_s  = sreg_r;
        case (state_r)
            ST_EMPTY: begin
                if (word_fire_s) begin
                    state_nxt_s = ST_SEND;
                    cnt_nxt_s   = {CW{1'b0}};
                    sreg_nxt_s  = upstream_data;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_SEND: begin
                if (beat_fire_s) begin
                    if (!is_last_s) begin
                        // Zero fill keeps the next beat at the low slice
                        sreg_nxt_s = sreg_r >> OUT_BITS;
                        cnt_nxt_s  = cnt_r + CNT_ONE;
                    end else if (word_fire_s) begin
                        state_nxt_s = ST_SEND;
                        cnt_nxt_s   = {CW{1'b0}};
                        sreg_nxt_s  = upstream_data;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                        cnt_nxt_s   = {CW{1'b0}};
                    end
                end else begin
                    // Stalled: beat and valid held stable
                    state_nxt_s = ST_SEND;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
                cnt_nxt_s   = {CW{1'b0}};
                sreg_nxt_s  = {IN_BITS{1'b0}};
            end
        endcase
    end

    // State registers with synchronous reset taking priority over handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
            cnt_r   <= {CW{1'b0}};
            sreg_r  <= {IN_BITS{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            sreg_r  <= sreg_nxt_s;
        end
    end

endmodule

// File: tb/tb_stream_downsizer.sv
// -----------------------------------------------------------------------------
// tb_stream_downsizer
// Self-checking bench for stream_downsizer (32 -> 8). Accepted words are
// expanded into expected beats in a queue; a monitor pops and compares each
// beat the DUT presents. Directed sequences cover reset, latency, back-to-back
// words, backpressure and mid-word reset, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_stream_downsizer;

    localparam int IN_BITS  = 32;
    localparam int OUT_BITS = 8;
    localparam int RATIO    = IN_BITS / OUT_BITS;

    logic                clk;
    logic                rst;
    logic [IN_BITS-1:0]  upstream_data;
    logic                upstream_valid;
    logic                upstream_ready;
    logic [OUT_BITS-1:0] downstream_data;
    logic                downstream_valid;
    logic                downstream_ready;
`ifdef STREAM_DOWNSIZER_LAST_EN
    logic                downstream_last;
`endif

    stream_downsizer #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) dut (
        .clk              (clk),
        .rst              (rst),
        .upstream_data    (upstream_data),
        .upstream_valid   (upstream_valid),
        .upstream_ready   (upstream_ready),
        .downstream_data  (downstream_data),
        .downstream_valid (downstream_valid),
        .downstream_ready (downstream_ready)
`ifdef STREAM_DOWNSIZER_LAST_EN
        ,
        .downstream_last  (downstream_last)
`endif
    );

    typedef struct {
        logic [OUT_BITS-1:0] data;
        logic                last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_err    = 0;

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard input: every accepted word becomes RATIO expected beats
    logic                sb_fire;
    logic                sb_rst;
    logic [IN_BITS-1:0]  sb_word;
    always @(negedge clk) begin
        sb_fire = !rst && upstream_valid && upstream_ready;
        sb_rst  = rst;
        sb_word = upstream_data;
        #1;
        if (sb_rst) begin
            exp_q.delete();
        end else if (sb_fire) begin
            for (int k = 0; k < RATIO; k++) begin
                beat_t b;
                b.data = OUT_BITS'((sb_word >> (k * OUT_BITS)) & ((1 << OUT_BITS) - 1));
                b.last = (k == RATIO - 1);
                exp_q.push_back(b);
            end
        end
    end

    // Monitor: compare presented beats and handshake against the scoreboard
    int                  pending;
    logic                prev_stall = 1'b0;
    logic [OUT_BITS-1:0] prev_data;
    always @(negedge clk) begin
        if (!rst) begin
            pending = exp_q.size();
            chk("mon_valid", {31'd0, downstream_valid}, {31'd0, pending != 0});
            chk("mon_up_ready", {31'd0, upstream_ready},
                {31'd0, (pending == 0) || (downstream_ready && pending == 1)});
            if (prev_stall) begin
                chk("mon_stable_data", {24'd0, downstream_data}, {24'd0, prev_data});
            end
            if (pending != 0 && downstream_valid) begin
                chk("mon_data", {24'd0, downstream_data}, {24'd0, exp_q[0].data});
`ifdef STREAM_DOWNSIZER_LAST_EN
                chk("mon_last", {31'd0, downstream_last}, {31'd0, exp_q[0].last});
`endif
                if (downstream_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
        prev_stall = !rst && downstream_valid && !downstream_ready;
        prev_data  = downstream_data;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check one presented beat at the next negedge
    task automatic expect_beat(input string name, input logic [7:0] d, input logic last);
        @(negedge clk);
        chk({name, "_valid"}, {31'd0, downstream_valid}, 32'd1);
        chk({name, "_data"}, {24'd0, downstream_data}, {24'd0, d});
`ifdef STREAM_DOWNSIZER_LAST_EN
        chk({name, "_last"}, {31'd0, downstream_last}, {31'd0, last});
`else
        if (last) begin end
`endif
    endtask

    // Present one word for exactly one accepting cycle (stage must be empty)
    task automatic send_word(input logic [31:0] w);
        upstream_data  = w;
        upstream_valid = 1'b1;
        @(negedge clk);
        chk("send_up_ready", {31'd0, upstream_ready}, 32'd1);
        cyc();
        upstream_valid = 1'b0;
        upstream_data  = $urandom;
    endtask

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        int          sent;
        int          iters;
        logic [7:0]  seq [8];

        rst              = 1'b1;
        upstream_valid   = 1'b1;
        upstream_data    = 32'hCAFEF00D;
        downstream_ready = 1'b1;

        // Reset held with a valid word offered
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_valid", {31'd0, downstream_valid}, 32'd0);
        chk("rst_data", {24'd0, downstream_data}, 32'd0);
        chk("rst_up_ready", {31'd0, upstream_ready}, 32'd1);
`ifdef STREAM_DOWNSIZER_LAST_EN
        chk("rst_last", {31'd0, downstream_last}, 32'd0);
`endif
        cyc();
        rst            = 1'b0;
        upstream_valid = 1'b0;
        cyc();

        // Single word, beats on consecutive cycles after accept
        send_word(32'hDDCCBBAA);
        expect_beat("single0", 8'hAA, 1'b0);
        expect_beat("single1", 8'hBB, 1'b0);
        expect_beat("single2", 8'hCC, 1'b0);
        expect_beat("single3", 8'hDD, 1'b1);
        @(negedge clk);
        chk("single_idle", {31'd0, downstream_valid}, 32'd0);
        cyc();

        // Back-to-back words with no gap
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        seq[4] = 8'h55; seq[5] = 8'h66; seq[6] = 8'h77; seq[7] = 8'h88;
        upstream_data  = 32'h44332211;
        upstream_valid = 1'b1;
        @(negedge clk);
        chk("b2b_accept_ready", {31'd0, upstream_ready}, 32'd1);
        cyc();
        upstream_data = 32'h88776655;
        for (int i = 0; i < 8; i++) begin
            expect_beat("b2b", seq[i], (i % RATIO) == RATIO - 1);
            chk("b2b_up_ready", {31'd0, upstream_ready}, {31'd0, (i % RATIO) == RATIO - 1});
            if (i == 3) begin
                cyc();
                upstream_valid = 1'b0;
            end else begin
                cyc();
            end
        end
        @(negedge clk);
        chk("b2b_idle", {31'd0, downstream_valid}, 32'd0);
        cyc();

        // Backpressure while 0xBB is presented
        send_word(32'hDDCCBBAA);
        expect_beat("bp0", 8'hAA, 1'b0);
        cyc();
        downstream_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_beat("bp_hold", 8'hBB, 1'b0);
            chk("bp_up_ready", {31'd0, upstream_ready}, 32'd0);
            cyc();
        end
        downstream_ready = 1'b1;
        expect_beat("bp_resume", 8'hBB, 1'b0);
        expect_beat("bp2", 8'hCC, 1'b0);
        expect_beat("bp3", 8'hDD, 1'b1);
        cyc();

        // Reset after the 0xBB beat; next word has no residue
        send_word(32'hDDCCBBAA);
        expect_beat("mr0", 8'hAA, 1'b0);
        expect_beat("mr1", 8'hBB, 1'b0);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("mr_valid_after_rst", {31'd0, downstream_valid}, 32'd0);
        cyc();
        send_word(32'h0F0E0D0C);
        expect_beat("mr_new0", 8'h0C, 1'b0);
        expect_beat("mr_new1", 8'h0D, 1'b0);
        expect_beat("mr_new2", 8'h0E, 1'b0);
        expect_beat("mr_new3", 8'h0F, 1'b1);
        cyc();

        // Randomized valid/ready toggling, checked by the monitor
        sent  = 0;
        iters = 0;
        while (sent < 1000 && iters < 40000) begin
            upstream_valid   = ($urandom_range(0, 3) != 0);
            w                = $urandom;
            upstream_data    = w;
            downstream_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (upstream_valid && upstream_ready) begin
                sent++;
            end
            cyc();
            iters++;
        end
        chk("rand_words_sent", sent, 32'd1000);

        // Drain remaining beats
        upstream_valid   = 1'b0;
        downstream_ready = 1'b1;
        iters = 0;
        while (exp_q.size() != 0 && iters < 100) begin
            cyc();
            iters++;
        end
        repeat (2) cyc();
        @(negedge clk);
        chk("drain_queue_empty", exp_q.size(), 32'd0);
        chk("drain_valid", {31'd0, downstream_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
